// File: rtl/pipe_tx_width_packer.sv
`default_nettype none
// ============================================================================
// Module   : pipe_tx_width_packer
// Brief    : Packs a MAC byte stream (symbol + K flag) into 8/16/32-bit PIPE
//            TX words. Partial words are flushed on in_last with PAD_SYM/K=1
//            in the unused lanes. Valid/ready flow control on both sides.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_tx_width_packer #(
  parameter int          PIPE_WIDTH = 32,
  parameter logic [7:0]  PAD_SYM    = 8'hF7,
  localparam int         NBYTES     = PIPE_WIDTH / 8
) (
  input  logic                  pclk,
  input  logic                  reset_n,
  input  logic [7:0]            in_data,
  input  logic                  in_datak,
  input  logic                  in_last,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [PIPE_WIDTH-1:0] tx_data,
  output logic [NBYTES-1:0]     tx_datak,
  output logic [NBYTES-1:0]     tx_lane_en,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic [15:0]           word_cnt
);

  // Lane index width; a single-lane build still needs a 1-bit index.
  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] c_LAST_LANE = IW'(NBYTES - 1);

  if (!(PIPE_WIDTH == 8 || PIPE_WIDTH == 16 || PIPE_WIDTH == 32)) begin : g_bad_width
    $error("pipe_tx_width_packer: PIPE_WIDTH must be 8, 16 or 32");
  end

  logic [IW-1:0]         r_idx;
  logic [PIPE_WIDTH-1:0] r_buf_data;
  logic [NBYTES-1:0]     r_buf_k;
  logic [NBYTES-1:0]     r_buf_en;
  logic [PIPE_WIDTH-1:0] r_tx_data;
  logic [NBYTES-1:0]     r_tx_k;
  logic [NBYTES-1:0]     r_tx_en;
  logic                  r_tx_valid;
  logic [15:0]           r_word_cnt;

  logic                  w_completes;
  logic                  w_accept;
  logic                  w_drain;
  logic [PIPE_WIDTH-1:0] w_buf_data;
  logic [NBYTES-1:0]     w_buf_k;
  logic [NBYTES-1:0]     w_buf_en;
  logic [PIPE_WIDTH-1:0] w_pad_data;
  logic [NBYTES-1:0]     w_pad_k;

  // Only the byte that closes a word can be stalled, and only by a full output register.
  always_comb begin
    w_completes = (r_idx == c_LAST_LANE) || in_last;
    in_ready    = !w_completes || !r_tx_valid || tx_ready;
    w_accept    = in_valid && in_ready;
    w_drain     = r_tx_valid && tx_ready;
  end

  // Merge the incoming byte into its lane, then pad every lane that holds no real byte.
  always_comb begin
    w_buf_data = r_buf_data;
    w_buf_k    = r_buf_k;
    w_buf_en   = r_buf_en;
    w_pad_data = '0;
    w_pad_k    = '0;
    for (int i = 0; i < NBYTES; i++) begin
      if (w_accept && (r_idx == IW'(i))) begin
        w_buf_data[i*8 +: 8] = in_data;
        w_buf_k[i]           = in_datak;
        w_buf_en[i]          = 1'b1;
      end
    end
    // Lanes fill contiguously from 0 and the buffer is cleared per word, so !en marks pad lanes.
    for (int i = 0; i < NBYTES; i++) begin
      if (w_buf_en[i]) begin
        w_pad_data[i*8 +: 8] = w_buf_data[i*8 +: 8];
        w_pad_k[i]           = w_buf_k[i];
      end else begin
        w_pad_data[i*8 +: 8] = PAD_SYM;
        w_pad_k[i]           = 1'b1;
      end
    end
  end

  // Accumulation buffer and lane index: advance on each byte, clear when a word completes.
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      r_idx      <= '0;
      r_buf_data <= '0;
      r_buf_k    <= '0;
      r_buf_en   <= '0;
    end else if (w_accept) begin
      if (w_completes) begin
        r_idx      <= '0;
        r_buf_data <= '0;
        r_buf_k    <= '0;
        r_buf_en   <= '0;
      end else begin
        r_idx      <= r_idx + IW'(1);
        r_buf_data <= w_buf_data;
        r_buf_k    <= w_buf_k;
        r_buf_en   <= w_buf_en;
      end
    end
  end

  // Output holding register: a completion reloads it (even while draining), a bare drain empties it.
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      r_tx_data  <= '0;
      r_tx_k     <= '0;
      r_tx_en    <= '0;
      r_tx_valid <= 1'b0;
    end else if (w_accept && w_completes) begin
      r_tx_data  <= w_pad_data;
      r_tx_k     <= w_pad_k;
      r_tx_en    <= w_buf_en;
      r_tx_valid <= 1'b1;
    end else if (w_drain) begin
      r_tx_valid <= 1'b0;
    end
  end

  // Saturating count of words handed to the PHY.
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      r_word_cnt <= '0;
    end else if (w_drain && (r_word_cnt != 16'hFFFF)) begin
      r_word_cnt <= r_word_cnt + 16'd1;
    end
  end

  assign tx_data    = r_tx_data;
  assign tx_datak   = r_tx_k;
  assign tx_lane_en = r_tx_en;
  assign tx_valid   = r_tx_valid;
  assign word_cnt   = r_word_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_tx_width_packer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_pipe_tx_width_packer
// Brief    : Self-checking bench for pipe_tx_width_packer at 32/16/8-bit
//            widths. A byte-queue reference model predicts each word.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_tx_width_packer;

  logic pclk = 1'b0;
  logic reset_n = 1'b0;
  always #5 pclk = ~pclk;

  // Shared drive, routed to the selected DUT.
  int unsigned sel = 0;
  logic [7:0] drv_data = '0;
  logic       drv_k = 1'b0, drv_last = 1'b0, drv_valid = 1'b0, drv_txr = 1'b1;

  logic        v32, v16, v8, r32, r16, r8;
  logic [31:0] d32;  logic [3:0] k32, e32;  logic txv32, inr32; logic [15:0] c32;
  logic [15:0] d16;  logic [1:0] k16, e16;  logic txv16, inr16; logic [15:0] c16;
  logic [7:0]  d8;   logic [0:0] k8,  e8;   logic txv8,  inr8;  logic [15:0] c8;

  assign v32 = drv_valid && (sel == 0);
  assign v16 = drv_valid && (sel == 1);
  assign v8  = drv_valid && (sel == 2);
  assign r32 = (sel == 0) ? drv_txr : 1'b1;
  assign r16 = (sel == 1) ? drv_txr : 1'b1;
  assign r8  = (sel == 2) ? drv_txr : 1'b1;

  pipe_tx_width_packer #(.PIPE_WIDTH(32)) u_dut32 (
    .pclk(pclk), .reset_n(reset_n), .in_data(drv_data), .in_datak(drv_k),
    .in_last(drv_last), .in_valid(v32), .in_ready(inr32), .tx_data(d32),
    .tx_datak(k32), .tx_lane_en(e32), .tx_valid(txv32), .tx_ready(r32), .word_cnt(c32));
  pipe_tx_width_packer #(.PIPE_WIDTH(16)) u_dut16 (
    .pclk(pclk), .reset_n(reset_n), .in_data(drv_data), .in_datak(drv_k),
    .in_last(drv_last), .in_valid(v16), .in_ready(inr16), .tx_data(d16),
    .tx_datak(k16), .tx_lane_en(e16), .tx_valid(txv16), .tx_ready(r16), .word_cnt(c16));
  pipe_tx_width_packer #(.PIPE_WIDTH(8)) u_dut8 (
    .pclk(pclk), .reset_n(reset_n), .in_data(drv_data), .in_datak(drv_k),
    .in_last(drv_last), .in_valid(v8), .in_ready(inr8), .tx_data(d8),
    .tx_datak(k8), .tx_lane_en(e8), .tx_valid(txv8), .tx_ready(r8), .word_cnt(c8));

  // Observed outputs of the selected DUT, zero-extended to 32-bit width.
  logic [31:0] obs_data;
  logic [3:0]  obs_k, obs_en;
  logic        obs_txv, obs_inr;
  logic [15:0] obs_cnt;
  always_comb begin
    obs_data = '0; obs_k = '0; obs_en = '0; obs_txv = 1'b0; obs_inr = 1'b0; obs_cnt = '0;
    case (sel)
      0: begin obs_data = d32; obs_k = k32; obs_en = e32; obs_txv = txv32; obs_inr = inr32; obs_cnt = c32; end
      1: begin obs_data = {16'h0, d16}; obs_k = {2'b0, k16}; obs_en = {2'b0, e16};
               obs_txv = txv16; obs_inr = inr16; obs_cnt = c16; end
      default: begin obs_data = {24'h0, d8}; obs_k = {3'b0, k8}; obs_en = {3'b0, e8};
               obs_txv = txv8; obs_inr = inr8; obs_cnt = c8; end
    endcase
  end

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  // Reference model: accepted bytes of the current word, the expected held word, counters per DUT.
  logic [8:0]  byte_q[$];
  logic        m_txv = 1'b0;
  logic [31:0] m_data = '0;
  logic [3:0]  m_k = '0, m_en = '0;
  logic [15:0] m_cnt[3] = '{16'h0, 16'h0, 16'h0};

  function automatic int nb();
    return (sel == 0) ? 4 : (sel == 1) ? 2 : 1;
  endfunction

  function automatic bit contiguous(input logic [3:0] en);
    logic [4:0] x;
    x = {1'b0, en};
    return ((x + 5'd1) & x) == 5'd0;
  endfunction

  // One clock cycle: drive at negedge, check in_ready, update model on the edge, check outputs.
  task automatic step(input bit v, input logic [7:0] d, input bit k, input bit l,
                      input bit txr, output bit acc);
    bit completes, exp_inr, hs, pre_txv, pre_hs;
    int n;
    drv_valid = v; drv_data = d; drv_k = k; drv_last = l; drv_txr = txr;
    #1;
    n = nb();
    completes = (byte_q.size() == n - 1) || l;
    exp_inr   = !completes || !m_txv || txr;
    check("in_ready", {31'b0, obs_inr}, {31'b0, exp_inr});
    acc     = v && exp_inr;
    hs      = m_txv && txr;
    pre_txv = obs_txv;
    pre_hs  = obs_txv && txr;
    @(posedge pclk); #1;
    if (hs && m_cnt[sel] != 16'hFFFF) m_cnt[sel] = m_cnt[sel] + 16'd1;
    if (acc) begin
      byte_q.push_back({k, d});
      if (completes) begin
        m_data = '0; m_k = '0; m_en = '0;
        for (int i = 0; i < n; i++) begin
          if (i < byte_q.size()) begin
            m_data[i*8 +: 8] = byte_q[i][7:0];
            m_k[i]  = byte_q[i][8];
            m_en[i] = 1'b1;
          end else begin
            m_data[i*8 +: 8] = 8'hF7;
            m_k[i] = 1'b1;
          end
        end
        byte_q.delete();
        m_txv = 1'b1;
      end else if (hs) m_txv = 1'b0;
    end else if (hs) m_txv = 1'b0;
    check("tx_valid", {31'b0, obs_txv}, {31'b0, m_txv});
    if (m_txv) begin
      check("tx_data", obs_data, m_data);
      check("tx_datak", {28'b0, obs_k}, {28'b0, m_k});
      check("tx_lane_en", {28'b0, obs_en}, {28'b0, m_en});
    end
    check("word_cnt", {16'b0, obs_cnt}, {16'b0, m_cnt[sel]});
    check("lane_en_contig", {31'b0, contiguous(obs_en)}, 32'd1);
    if (pre_txv && !pre_hs) check("txv_no_drop", {31'b0, obs_txv}, 32'd1);
    @(negedge pclk);
  endtask

  // Offer one byte until it is accepted, bounded.
  task automatic send(input logic [7:0] d, input bit k, input bit l, input bit txr);
    bit acc;
    for (int t = 0; t < 50; t++) begin
      step(1'b1, d, k, l, txr, acc);
      if (acc) return;
    end
    check("send_timeout", 32'd0, 32'd1);
  endtask

  // Close any open packet and empty the output register before switching DUTs.
  task automatic drain();
    bit acc;
    if (byte_q.size() != 0) send(8'h5A, 1'b0, 1'b1, 1'b1);
    for (int t = 0; t < 20 && m_txv; t++) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, acc);
    check("drain_empty", {31'b0, obs_txv}, 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_txv"}, {31'b0, obs_txv}, 32'd0);
    check({tag, "_data"}, obs_data, 32'd0);
    check({tag, "_k"}, {28'b0, obs_k}, 32'd0);
    check({tag, "_en"}, {28'b0, obs_en}, 32'd0);
    check({tag, "_cnt"}, {16'b0, obs_cnt}, 32'd0);
    check({tag, "_inr"}, {31'b0, obs_inr}, 32'd1);
  endtask

  initial begin
    bit acc;
    logic [7:0] bytes4[4];

    // Power-on reset
    @(negedge pclk); #1;
    check_reset_outputs("por");
    @(negedge pclk);
    reset_n = 1'b1;

    // 32-bit: two full words at full rate
    sel = 0;
    bytes4 = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) send(bytes4[i], 1'b0, 1'b0, 1'b1);
    check("t1_word0", obs_data, 32'h44332211);
    check("t1_en0", {28'b0, obs_en}, 32'hF);
    bytes4 = '{8'h55, 8'h66, 8'h77, 8'h88};
    for (int i = 0; i < 4; i++) send(bytes4[i], 1'b0, 1'b0, 1'b1);
    check("t1_word1", obs_data, 32'h88776655);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, acc);
    check("t1_cnt", {16'b0, obs_cnt}, 32'd2);

    // 32-bit: short packet flushed with padding
    send(8'hBC, 1'b1, 1'b0, 1'b1);
    send(8'hAA, 1'b0, 1'b0, 1'b1);
    send(8'hBB, 1'b0, 1'b1, 1'b1);
    check("t2_data", obs_data, 32'hF7BBAABC);
    check("t2_k", {28'b0, obs_k}, 32'b1001);
    check("t2_en", {28'b0, obs_en}, 32'b0111);
    drain();

    // 16-bit: backpressure holds word and stalls only the completing byte
    sel = 1;
    step(1'b1, 8'h01, 1'b0, 1'b0, 1'b0, acc);
    check("t3_b01_acc", {31'b0, acc}, 32'd1);
    step(1'b1, 8'h02, 1'b0, 1'b0, 1'b0, acc);
    step(1'b1, 8'h03, 1'b0, 1'b0, 1'b0, acc);
    step(1'b1, 8'h04, 1'b0, 1'b0, 1'b0, acc);
    check("t3_b04_stall", {31'b0, acc}, 32'd0);
    check("t3_hold", obs_data, 32'h0201);
    step(1'b1, 8'h04, 1'b0, 1'b0, 1'b0, acc);
    check("t3_hold2", obs_data, 32'h0201);
    step(1'b1, 8'h04, 1'b0, 1'b0, 1'b1, acc);
    check("t3_b04_acc", {31'b0, acc}, 32'd1);
    check("t3_word1", obs_data, 32'h0403);
    drain();

    // 8-bit: continuous stream, one word per cycle
    sel = 2;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 8'(i * 17 + 3), 1'b0, 1'b0, 1'b1, acc);
      check("t4_inr", {31'b0, acc}, 32'd1);
      check("t4_txv", {31'b0, obs_txv}, 32'd1);
    end
    drain();

    // 32-bit: reset mid-word discards partial bytes
    sel = 0;
    send(8'h01, 1'b0, 1'b0, 1'b1);
    send(8'h02, 1'b0, 1'b0, 1'b1);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("rst");
    byte_q.delete(); m_txv = 1'b0;
    m_cnt = '{16'h0, 16'h0, 16'h0};
    @(negedge pclk);
    reset_n = 1'b1;
    bytes4 = '{8'h9A, 8'hBC, 8'hDE, 8'hF0};
    for (int i = 0; i < 4; i++) send(bytes4[i], 1'b0, 1'b0, 1'b1);
    check("t5_word", obs_data, 32'hF0DEBC9A);
    drain();

    // Randomized traffic on each width against the model
    for (int s = 0; s < 3; s++) begin
      sel = s;
      for (int i = 0; i < 300; i++)
        step(($urandom % 4) != 0, 8'($urandom), ($urandom % 8) == 0,
             ($urandom % 5) == 0, ($urandom % 3) != 0, acc);
      drain();
    end

    // 8-bit: drive word_cnt to saturation
    sel = 2;
    for (int t = 0; t < 70000 && m_cnt[2] != 16'hFFFE; t++)
      step(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b1, acc);
    check("t6_pre", {16'b0, m_cnt[2]}, 32'hFFFE);
    for (int i = 0; i < 3; i++) send(8'($urandom), 1'b0, 1'b0, 1'b1);
    drain();
    check("t6_sat", {16'b0, obs_cnt}, 32'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_tx_width_packer.md
Name: pipe_tx_width_packer

Overview:
- Gathers the MAC-side byte stream (one symbol plus K flag per beat) into PIPE TX words of 8, 16 or 32 bits for the PHY TxData/TxDataK bus.
- Sits directly upstream of the PIPE interface, between the MAC transmit framer and the PHY.
- Flushes partial words at packet end, padding the unused lanes, and applies valid/ready backpressure in both directions.

Parameters:
- PIPE_WIDTH, 32, TxData width in bits; legal values are 8, 16 and 32. Any other value is rejected by an elaboration-time assertion.
- NBYTES, PIPE_WIDTH/8, derived local parameter giving the byte lanes per word.
- PAD_SYM, 8'hF7, symbol inserted into unused lanes on a flush; the K flag is forced to 1.

Ports:
- pclk  in  1  PIPE clock; all logic is on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_data  in  8  MAC symbol.
- in_datak  in  1  1 = K-character.
- in_last  in  1  last byte of a packet; forces a flush.
- in_valid  in  1  a byte is offered.
- in_ready  out  1  the packer accepts the byte this cycle.
- tx_data  out  PIPE_WIDTH  packed word; byte lane 0 is [7:0] and carries the first byte.
- tx_datak  out  NBYTES  per-lane K flags.
- tx_lane_en  out  NBYTES  per-lane mask; 1 = real byte, 0 = pad.
- tx_valid  out  1  the word is valid.
- tx_ready  in  1  the PHY accepts the word.
- word_cnt  out  16  count of words transferred; saturates at 16'hFFFF.

Behaviour:
- Reset (asynchronous assert, release synchronous to pclk):
  - Outputs: tx_valid=0, tx_data=0, tx_datak=0, tx_lane_en=0, word_cnt=0.
  - Internal: lane index idx=0, accumulation buffer cleared, in_ready=1.
  - Assertion mid-word discards the partial bytes. Assertion while tx_valid=1 drops the held word.
- Accept: a byte is accepted when in_valid && in_ready.
  - The byte is written to buffer lane idx with its K flag, and lane_en[idx] is set to 1.
- Completion: an accepted byte completes the word if idx==NBYTES-1 or in_last=1.
- in_ready:
  - in_ready = 1 when the byte would not complete a word.
  - Otherwise in_ready = !tx_valid || tx_ready.
  - So intermediate bytes are never stalled, and only the completing byte waits for the output register.
  - in_ready is combinational from idx, in_last, tx_valid and tx_ready.
- On completion:
  - The buffer, with the current byte merged in, loads the output register on the same edge.
  - Lanes above idx are filled with PAD_SYM, K=1, lane_en=0.
  - tx_valid=1 from the next cycle, so latency is 1 cycle from acceptance of the completing byte.
  - idx returns to 0 and the buffer is cleared.
- Otherwise idx increments by 1 on each accepted byte.
- Output hold: tx_data, tx_datak and tx_lane_en stay stable while tx_valid && !tx_ready.
- Output drain:
  - On tx_valid && tx_ready with no new completion, tx_valid is 0 next cycle.
  - A simultaneous drain and completion reloads the register, so tx_valid stays 1 with back-to-back words at full throughput.
- word_cnt increments by 1 on each tx_valid && tx_ready handshake and holds at 16'hFFFF.
- in_last at idx==0 produces a single-lane word: lane_en = NBYTES'b...01.
- PIPE_WIDTH=8: every accepted byte completes a word, and tx_lane_en is always 1.
- Sequencing: one output holding register plus one accumulation buffer, with no state machine beyond idx. The states are FILL (idx<NBYTES-1) and COMPLETE-pending.
- Invariants (the bench asserts both):
  - tx_valid never drops without a handshake, except on reset.
  - tx_lane_en is always a contiguous run of 1s starting from lane 0.

Test Plan:
- PIPE_WIDTH=32, tx_ready=1, bytes 11,22,33,44 (K=0) then 55,66,77,88 -> tx_data=32'h44332211 the cycle after byte 44 is accepted, then 32'h88776655; tx_lane_en=4'hF; word_cnt=2.
- PIPE_WIDTH=32, bytes BC(K=1),AA,BB with in_last on BB -> tx_data=32'hF7BBAABC, tx_datak=4'b1001, tx_lane_en=4'b0111.
- PIPE_WIDTH=16, tx_ready=0 for 5 cycles, stream 01..04 ->
  - in_ready=1 for byte 01.
  - in_ready=0 on byte 04 while word 16'h0201 is held stable.
  - After tx_ready=1, words 16'h0201 then 16'h0403 with no byte lost.
- PIPE_WIDTH=8, continuous in_valid, tx_ready=1 -> one word per cycle, tx_valid held at 1, in_ready constantly 1.
- reset_n pulsed low after 2 bytes in 32-bit mode -> all outputs 0 immediately; the next bytes 9A,BC,DE,F0 yield 32'hF0DEBC9A.
- Force word_cnt to FFFE, then complete 3 words -> word_cnt=FFFF and it stays there.
